// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types and helpers for the lsu_rmw load/store unit:
//                FSM state encoding, RISC-V load/store width codes, and
//                width-classification helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_MERGE = 2'd2,
        S_WRITE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte/halfword codes need a read-modify-write on store. Anything else,
    // including the undefined codes, behaves as a whole-word access.
    function automatic logic is_subword(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Misaligned halfword, misaligned word, or an undefined width code.
    function automatic logic req_illegal(input logic [2:0] f3, input logic [1:0] lo);
        logic r;
        case (f3)
            F3_B, F3_BU: r = 1'b0;
            F3_H, F3_HU: r = lo[0];
            F3_W:        r = (lo != 2'b00);
            default:     r = 1'b1;
        endcase
        return r;
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_lane
//  Description : Combinational lane logic. Extracts and sign/zero-extends
//                the addressed byte/halfword of a memory word for loads, and
//                merges store data into the addressed lanes for sub-word
//                stores. Halfword lane selection uses addr[1] only.
//  Ports       : word_i      - word read from memory
//                addr_lo_i   - byte offset within the word
//                funct3_i    - width code
//                wdata_i     - right-aligned store data (low half is all that
//                              a sub-word merge can use)
//                load_o      - extended load result
//                merge_o     - word with store lanes replaced
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word_i[7:0];
        case (addr_lo_i)
            2'd0: w_byte = word_i[7:0];
            2'd1: w_byte = word_i[15:8];
            2'd2: w_byte = word_i[23:16];
            2'd3: w_byte = word_i[31:24];
            default: w_byte = word_i[7:0];
        endcase
        w_half = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        load_o = word_i;
        case (funct3_i)
            F3_B:    load_o = {{24{w_byte[7]}}, w_byte};
            F3_BU:   load_o = {24'd0, w_byte};
            F3_H:    load_o = {{16{w_half[15]}}, w_half};
            F3_HU:   load_o = {16'd0, w_half};
            default: load_o = word_i;
        endcase
    end

    always_comb begin
        merge_o = word_i;
        case (funct3_i)
            F3_B, F3_BU: begin
                case (addr_lo_i)
                    2'd0: merge_o[7:0]   = wdata_i[7:0];
                    2'd1: merge_o[15:8]  = wdata_i[7:0];
                    2'd2: merge_o[23:16] = wdata_i[7:0];
                    2'd3: merge_o[31:24] = wdata_i[7:0];
                    default: merge_o = word_i;
                endcase
            end
            F3_H, F3_HU: begin
                if (addr_lo_i[1]) merge_o[31:16] = wdata_i;
                else              merge_o[15:0]  = wdata_i;
            end
            default: merge_o = word_i;
        endcase
    end

endmodule : lsu_lane
`default_nettype wire

// File: rtl/lsu_rmw.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_rmw
//  Description : Load/store unit in front of a 32-word, word-only,
//                single-port data memory with a one-cycle registered read.
//                Sub-word stores become read-modify-write sequences; loads
//                are lane-extracted and extended.
//  Ports       : clk/rst         - clock, synchronous active-high reset
//                req_*           - execute-stage request (accepted in IDLE)
//                rsp_*           - completion pulse, load data, error flag
//                mem_*           - word-wide memory port
//  Options     : LSU_MISALIGN_CHECK_EN - when defined, misaligned or
//                undefined-width requests complete in one cycle with
//                rsp_err=1 and no memory access. When undefined, rsp_err is
//                tied low and offending low address bits are truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_rw,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [1:0]        addr_lo_q;
    logic [15:0]       wdata_q;
    logic [31:0]       wbuf_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;

    logic [31:0] lane_load_d;
    logic [31:0] lane_merge_d;
    logic        bad_d;
    logic        accept_d;

    // Upper address bits only select aliases of the 128-byte space.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W];

    assign accept_d = req_valid && (state_q == S_IDLE);

`ifdef LSU_MISALIGN_CHECK_EN
    logic rsp_err_q;
    assign bad_d   = req_illegal(req_funct3, req_addr[1:0]);
    assign rsp_err = rsp_err_q;
`else
    assign bad_d   = 1'b0;
    assign rsp_err = 1'b0;
`endif

    lsu_lane u_lane (
        .word_i    (mem_rdata),
        .addr_lo_i (addr_lo_q),
        .funct3_i  (funct3_q),
        .wdata_i   (wdata_q),
        .load_o    (lane_load_d),
        .merge_o   (lane_merge_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= F3_W;
            addr_lo_q   <= 2'b00;
            wdata_q     <= 16'd0;
            wbuf_q      <= 32'd0;
            mem_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
`ifdef LSU_MISALIGN_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        addr_lo_q <= req_addr[1:0];
                        wdata_q   <= req_wdata[15:0];
                        if (bad_d) begin
                            // Rejected without touching memory; rsp_rdata holds.
                            rsp_valid_q <= 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
                            rsp_err_q   <= 1'b1;
`endif
                        end else begin
`ifdef LSU_MISALIGN_CHECK_EN
                            rsp_err_q  <= 1'b0;
`endif
                            // Address is presented from the accept edge so the
                            // memory sees it during READ/WRITE.
                            mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (req_we && !is_subword(req_funct3)) begin
                                wbuf_q  <= req_wdata;
                                state_q <= S_WRITE;
                            end else begin
                                state_q <= S_READ;
                            end
                        end
                    end
                end
                S_READ: begin
                    state_q <= S_MERGE;
                end
                S_MERGE: begin
                    if (!we_q) begin
                        rsp_rdata_q <= lane_load_d;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        wbuf_q  <= lane_merge_d;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = wbuf_q;
    // Reset gates the write strobe immediately so an interrupted store never
    // commits on the edge that applies the reset.
    assign mem_rw    = (state_q == S_WRITE) && !rst;

endmodule : lsu_rmw
`default_nettype wire

// File: tb/tb_lsu_rmw.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_rmw
//  Description : Directed self-checking bench for lsu_rmw with a behavioural
//                32-word registered-read memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_rmw;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;

    logic [31:0] mem [32];

    int checks = 0;
    int errors = 0;

    lsu_rmw #(.ADDR_W(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rw     (mem_rw),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-only memory, registered read (old data on same-address write).
    always @(posedge clk) begin
        if (mem_rw) mem[mem_addr[6:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[6:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE and observe 8 cycles. Cycle numbers count
    // from the accept cycle (0); -1 means never seen.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int rcyc, output int rwn,
                          output int rwcyc, output logic err, output logic [31:0] addr1);
        @(negedge clk);
        chk("ready_at_issue", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h5A5A_5A5A;
        req_funct3 = 3'b111;
        req_we     = ~we;
        rcyc  = -1;
        rwn   = 0;
        rwcyc = -1;
        err   = 1'bx;
        addr1 = 32'hx;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) addr1 = {25'd0, mem_addr};
            if (mem_rw) begin
                rwn++;
                if (rwcyc < 0) rwcyc = c;
            end
            if (rsp_valid && rcyc < 0) begin
                rcyc = c;
                err  = rsp_err;
            end
        end
    endtask

    int          rc, rn, rwc;
    logic        er;
    logic [31:0] a1;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        mem[0] = 32'h8899AABB;
        mem[2] = 32'h11223344;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_mem_addr", {25'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);

        // Loads from word 0 = 0x8899AABB.
        do_req(1'b0, 3'b000, 32'h01, 32'd0, rc, rn, rwc, er, a1);
        chk("lb01_data", rsp_rdata, 32'hFFFFFFAA);
        chk("lb01_cycle", rc, 32'd3);
        chk("lb01_no_write", rn, 32'd0);
        do_req(1'b0, 3'b100, 32'h03, 32'd0, rc, rn, rwc, er, a1);
        chk("lbu03_data", rsp_rdata, 32'h00000088);
        do_req(1'b0, 3'b001, 32'h02, 32'd0, rc, rn, rwc, er, a1);
        chk("lh02_data", rsp_rdata, 32'hFFFF8899);
        do_req(1'b0, 3'b101, 32'h02, 32'd0, rc, rn, rwc, er, a1);
        chk("lhu02_data", rsp_rdata, 32'h00008899);
        do_req(1'b0, 3'b010, 32'h00, 32'd0, rc, rn, rwc, er, a1);
        chk("lw00_data", rsp_rdata, 32'h8899AABB);
        chk("lw00_err", {31'd0, er}, 32'd0);

        // Loads from word 2 = 0x11223344.
        do_req(1'b0, 3'b001, 32'h08, 32'd0, rc, rn, rwc, er, a1);
        chk("lh08_data", rsp_rdata, 32'h00003344);
        do_req(1'b0, 3'b000, 32'h0A, 32'd0, rc, rn, rwc, er, a1);
        chk("lb0a_data", rsp_rdata, 32'h00000022);

        // SB 0x12 -> addr 0x05 over word 1 = 0.
        do_req(1'b1, 3'b000, 32'h05, 32'hFFFFFF12, rc, rn, rwc, er, a1);
        chk("sb05_word", mem[1], 32'h00001200);
        chk("sb05_rw_count", rn, 32'd1);
        chk("sb05_rw_cycle", rwc, 32'd3);
        chk("sb05_rsp_cycle", rc, 32'd4);
        chk("sb05_rdata_held", rsp_rdata, 32'h00000022);

        // SH 0xBEEF -> addr 0x06 over word 1 = 0x00001200.
        do_req(1'b1, 3'b001, 32'h06, 32'h1234BEEF, rc, rn, rwc, er, a1);
        chk("sh06_word", mem[1], 32'hBEEF1200);
        chk("sh06_rsp_cycle", rc, 32'd4);

        // Word store then wrapped word load.
        do_req(1'b1, 3'b010, 32'h7C, 32'hDEADBEEF, rc, rn, rwc, er, a1);
        chk("sw7c_rsp_cycle", rc, 32'd2);
        chk("sw7c_rw_cycle", rwc, 32'd1);
        chk("sw7c_word", mem[31], 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'hFC, 32'd0, rc, rn, rwc, er, a1);
        chk("lwfc_data", rsp_rdata, 32'hDEADBEEF);
        chk("lwfc_mem_addr", a1, 32'h7C);

        // Misaligned word load and undefined width code.
        do_req(1'b0, 3'b010, 32'h06, 32'd0, rc, rn, rwc, er, a1);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("lw06_cycle", rc, 32'd1);
        chk("lw06_err", {31'd0, er}, 32'd1);
        chk("lw06_no_write", rn, 32'd0);
        chk("lw06_rdata_held", rsp_rdata, 32'hDEADBEEF);
`else
        chk("lw06_cycle", rc, 32'd3);
        chk("lw06_err", {31'd0, er}, 32'd0);
        chk("lw06_data", rsp_rdata, 32'hBEEF1200);
`endif
        do_req(1'b0, 3'b011, 32'h08, 32'd0, rc, rn, rwc, er, a1);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("f3_011_err", {31'd0, er}, 32'd1);
        chk("f3_011_rdata_held", rsp_rdata, 32'hDEADBEEF);
`else
        chk("f3_011_err", {31'd0, er}, 32'd0);
        chk("f3_011_data", rsp_rdata, 32'h11223344);
`endif

        // Back-to-back: word store, then load accepted in the store's rsp cycle.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h10; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_busy", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("b2b_st_rsp", {31'd0, rsp_valid}, 32'd1);
        chk("b2b_st_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_ld_rsp", {31'd0, rsp_valid}, 32'd1);
        chk("b2b_ld_data", rsp_rdata, 32'hCAFEF00D);

        // Reset during the WRITE cycle of an SH to word 2.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h0A; req_wdata = 32'h00007777;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rstw_mem_rw", {31'd0, mem_rw}, 32'd0);
        chk("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstw_ready", {31'd0, req_ready}, 32'd1);
        chk("rstw_no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("rstw_word2", mem[2], 32'h11223344);
        chk("rstw_rdata", rsp_rdata, 32'd0);
        repeat (4) @(negedge clk);
        chk("rstw_word2_late", mem[2], 32'h11223344);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lsu_rmw
`default_nettype wire
